bias_act_pipe: RTL and testbench
================================

Name: bias_act_pipe

Overview:
Per-lane bias-add plus selectable activation for the systolic array output path. It sits between the accumulator drain and the output buffer.
Next-generation bias/ReLU stage:
- ARRAY_N lanes, all parametrised.
- Saturating signed add.
- Four activation modes.
- Two-stage valid/ready pipeline with full back-pressure.
- Bias register file loadable while data is streaming.

Parameters:
ARRAY_N, 16, number of SIMD lanes (power of two, >=2)
DATA_WIDTH, 32, signed width of data_in lane, bias, and data_out lane
LEAKY_SHIFT, 3, arithmetic right-shift amount applied to negative values in leaky mode

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
bias_wr_en  input  1  bias register write strobe
bias_wr_index  input  $clog2(ARRAY_N)  lane index for bias write
bias_wr_data  input  DATA_WIDTH  signed bias value
act_mode  input  2  activation select, sampled with each accepted input beat
clip_max  input  DATA_WIDTH  signed upper bound for clipped-ReLU, sampled with each accepted beat
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat
data_in  input  ARRAY_N*DATA_WIDTH  packed signed lanes, lane i at [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i]
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts
data_out  output  ARRAY_N*DATA_WIDTH  packed result lanes

Behaviour:
- Reset, synchronous with clk, active-high:
  - all bias registers 0; s1_valid = s2_valid = 0; out_valid = 0; data_out = 0.
  - in_ready = 1 in the cycle after reset deasserts.
- Bias write: on a clk edge with bias_wr_en = 1, bias[bias_wr_index] <= bias_wr_data.
  - A beat accepted in the same cycle uses the OLD bias; the new value applies from the next accepted beat.
  - reset has priority over a simultaneous write.
- Handshake:
  - A beat transfers when in_valid && in_ready, or out_valid && out_ready.
  - data_out holds stable while out_valid && !out_ready.
  - in_ready is not combinationally dependent on in_valid.
- Stage 1 (S1), on accept, registers per lane:
  - sum = sat(data_in[i] + bias[i]), computed in DATA_WIDTH+1 bits and clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Also registers act_mode and clip_max.
- Stage 2 (S2) applies the activation to sum:
  - 00 bypass: y = sum.
  - 01 ReLU: y = (sum < 0) ? 0 : sum.
  - 10 clipped ReLU: y = min(max(sum, 0), clip_max). If clip_max < 0, y = 0.
  - 11 leaky: y = (sum < 0) ? (sum >>> LEAKY_SHIFT) : sum.
- Pipeline control:
  - Each stage advances when its downstream is empty or being drained: s2_ready = !s2_valid || out_ready; s1_ready = !s1_valid || s2_ready; in_ready = s1_ready.
  - Latency is 2 cycles from accept to out_valid with out_ready held high.
  - Throughput is 1 beat/cycle.
  - No beat is dropped or duplicated under any out_ready pattern.
- Mid-operation reset flushes both stages; in-flight beats are discarded and biases are cleared.
- Boundaries:
  - Positive overflow clamps to max; negative overflow clamps to min (before activation).
  - Full pipeline plus out_ready = 0 drives in_ready = 0.

Optional Feature:
BIAS_ACT_SAT_CNT_EN
- Defined: adds output port sat_count (16 bits).
  - Counts output beats (out_valid && out_ready) in which at least one lane saturated in S1.
  - The counter saturates at 16'hFFFF and clears on reset.
  - The saturation flag travels with the beat through S2.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package bias_act_pkg:
  - act_mode localparams ACT_BYPASS = 2'd0, ACT_RELU = 2'd1, ACT_CLIP = 2'd2, ACT_LEAKY = 2'd3.
  - Helper constants for the signed max/min of DATA_WIDTH.
- Sub-module bias_act_lane: one lane's saturating add and activation mux, purely combinational. It outputs sum, y, and the saturation flag.
- Top level holds the bias file, the pipeline registers and valid/ready control, and a generate loop over bias_act_lane.

Test Plan:
- Reset, then write bias[3] = 100 and bias[0] = -50. Drive data_in all lanes = 10, mode 01, out_ready = 1 -> after 2 cycles lane3 = 110, lane0 = 0, other lanes = 10.
- Saturation, mode 00: lane0 data 0x7FFFFFF0 + bias 0x100 -> 0x7FFFFFFF; lane1 0x80000000 + bias -1 -> 0x80000000. With the macro defined, sat_count = 1 after the beat.
- Modes, bias 0, LEAKY_SHIFT = 3, clip_max = 50:
  - data 80 in mode 10 -> 50; data -5 in mode 10 -> 0.
  - data -64 in mode 11 -> -8; data -64 in mode 00 -> -64.
- Back-pressure: stream 8 beats with values 1..8 while out_ready toggles 1,0,0,1 repeating -> exactly 8 outputs in order. in_ready drops only when both stages are full, and data_out is stable during stalls.
- Concurrent write: a cycle with bias_wr_en lane2 = 7 plus an accepted beat of 1 -> that beat's lane2 = old bias + 1; the next beat of 1 -> lane2 = 8.
- Assert reset with 2 beats in flight -> out_valid = 0 and data_out = 0 next cycle, all biases read back as 0 via a subsequent beat of 0 in mode 00.

Source files
------------

// File: rtl/bias_act_pkg.sv
// bias_act_pkg: shared constants for the bias-add / activation stage.
// Activation select encodings and helpers for the signed saturation limits
// of a given data width. Optional build macro used by the block:
// BIAS_ACT_SAT_CNT_EN (adds the sat_count output on bias_act_pipe).
package bias_act_pkg;

  // Activation select encodings carried on act_mode
  localparam logic [1:0] ACT_BYPASS = 2'd0;
  localparam logic [1:0] ACT_RELU   = 2'd1;
  localparam logic [1:0] ACT_CLIP   = 2'd2;
  localparam logic [1:0] ACT_LEAKY  = 2'd3;

  // Widest data width the limit helpers below can describe
  localparam int MAX_DATA_WIDTH = 64;

  // Largest signed value representable in 'width' bits, zero-extended to 64 bits
  function automatic logic [MAX_DATA_WIDTH-1:0] signed_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  // Smallest signed value representable in 'width' bits; truncate to 'width'
  // bits at the use site to get the two's complement pattern 100...0
  function automatic logic [MAX_DATA_WIDTH-1:0] signed_min(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/bias_act_pipe_lane.sv
// bias_act_lane: one lane of the bias/activation datapath, purely
// combinational. The add half feeds the S1 register; the activation half
// works on the S1 register contents and feeds the S2 register. Both halves
// live here so the per-lane arithmetic is in one place.
module bias_act_lane
  import bias_act_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] bias,
  output logic [DATA_WIDTH-1:0] sum,
  output logic                  sat,
  input  logic [DATA_WIDTH-1:0] act_sum,
  input  logic [1:0]            act_mode,
  input  logic [DATA_WIDTH-1:0] clip_max,
  output logic [DATA_WIDTH-1:0] y
);

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = DATA_WIDTH'(signed_max(DATA_WIDTH));
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = DATA_WIDTH'(signed_min(DATA_WIDTH));

  logic [DATA_WIDTH:0] add_wide;
  logic                sum_neg;
  logic                clip_neg;

  // Sign-extended add one bit wider than the data; the top two bits disagree
  // exactly when the true result does not fit, and the top bit then tells
  // which rail to clamp to.
  always_comb begin
    add_wide = {data_in[DATA_WIDTH-1], data_in} + {bias[DATA_WIDTH-1], bias};
    sat      = add_wide[DATA_WIDTH] ^ add_wide[DATA_WIDTH-1];
    sum      = add_wide[DATA_WIDTH-1:0];
    if (sat) begin
      sum = add_wide[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

  assign sum_neg  = act_sum[DATA_WIDTH-1];
  assign clip_neg = clip_max[DATA_WIDTH-1];

  // Activation mux; a negative clip bound forces clipped-ReLU to zero rather
  // than passing the negative bound through.
  always_comb begin
    y = act_sum;
    case (act_mode)
      ACT_BYPASS: y = act_sum;
      ACT_RELU:   y = sum_neg ? '0 : act_sum;
      ACT_CLIP: begin
        if (clip_neg || sum_neg) begin
          y = '0;
        end else if ($signed(act_sum) > $signed(clip_max)) begin
          y = clip_max;
        end else begin
          y = act_sum;
        end
      end
      ACT_LEAKY:  y = sum_neg ? DATA_WIDTH'($signed(act_sum) >>> LEAKY_SHIFT) : act_sum;
      default:    y = act_sum;
    endcase
  end

endmodule

// File: rtl/bias_act_pipe.sv
// bias_act_pipe: per-lane saturating bias add plus selectable activation,
// between the accumulator drain and the output buffer. Two register stages
// (S1 = biased sum, S2 = activated result) with valid/ready back-pressure.
// Optional build macro: BIAS_ACT_SAT_CNT_EN adds the 16-bit sat_count output
// counting delivered beats in which any lane saturated during the bias add.
module bias_act_pipe
  import bias_act_pkg::*;
#(
  parameter int ARRAY_N     = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bias_wr_en,
  input  logic [$clog2(ARRAY_N)-1:0]    bias_wr_index,
  input  logic [DATA_WIDTH-1:0]         bias_wr_data,
  input  logic [1:0]                    act_mode,
  input  logic [DATA_WIDTH-1:0]         clip_max,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ARRAY_N*DATA_WIDTH-1:0] data_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ARRAY_N*DATA_WIDTH-1:0] data_out
`ifdef BIAS_ACT_SAT_CNT_EN
  ,
  output logic [15:0]                   sat_count
`endif
);

  logic [DATA_WIDTH-1:0]         bias_q [ARRAY_N];

  logic [ARRAY_N*DATA_WIDTH-1:0] sum_next;
  logic [ARRAY_N*DATA_WIDTH-1:0] y_next;
  logic [ARRAY_N-1:0]            sat_lane;

  logic                          s1_valid;
  logic [ARRAY_N*DATA_WIDTH-1:0] s1_sum;
  logic [1:0]                    s1_mode;
  logic [DATA_WIDTH-1:0]         s1_clip;
  logic                          s2_valid;

  logic                          s1_ready;
  logic                          s2_ready;

  // Each stage may load when it is empty or its contents are leaving this
  // cycle; in_ready therefore depends only on registered state and out_ready.
  assign s2_ready  = !s2_valid || out_ready;
  assign s1_ready  = !s1_valid || s2_ready;
  assign in_ready  = s1_ready;
  assign out_valid = s2_valid;

  // Per-lane arithmetic; the add side sees the live input beat and the
  // current bias, the activation side sees what S1 captured.
  for (genvar g = 0; g < ARRAY_N; g++) begin : g_lane
    bias_act_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .LEAKY_SHIFT (LEAKY_SHIFT)
    ) u_lane (
      .data_in  (data_in[g*DATA_WIDTH +: DATA_WIDTH]),
      .bias     (bias_q[g]),
      .sum      (sum_next[g*DATA_WIDTH +: DATA_WIDTH]),
      .sat      (sat_lane[g]),
      .act_sum  (s1_sum[g*DATA_WIDTH +: DATA_WIDTH]),
      .act_mode (s1_mode),
      .clip_max (s1_clip),
      .y        (y_next[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Bias register file; a beat accepted on the same edge as a write already
  // read the old value through sum_next, so no bypass is wanted here.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARRAY_N; i++) begin
        bias_q[i] <= '0;
      end
    end else if (bias_wr_en) begin
      bias_q[bias_wr_index] <= bias_wr_data;
    end
  end

  // S1: capture the saturated sums and the activation controls of the beat
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_mode  <= ACT_BYPASS;
      s1_clip  <= '0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum  <= sum_next;
        s1_mode <= act_mode;
        s1_clip <= clip_max;
      end
    end
  end

  // S2: capture the activated result; data_out only moves when S2 can load,
  // so it holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      data_out <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        data_out <= y_next;
      end
    end
  end

`ifdef BIAS_ACT_SAT_CNT_EN
  logic s1_sat;
  logic s2_sat;

  // Saturation flag rides alongside the beat through both stages
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_sat <= 1'b0;
      s2_sat <= 1'b0;
    end else begin
      if (s1_ready && in_valid) begin
        s1_sat <= |sat_lane;
      end
      if (s2_ready && s1_valid) begin
        s2_sat <= s1_sat;
      end
    end
  end

  // Count delivered beats that saw saturation, sticking at all-ones
  always_ff @(posedge clk) begin
    if (reset) begin
      sat_count <= '0;
    end else if (s2_valid && out_ready && s2_sat && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`else
  // Saturation flags have no consumer without the counter
  logic unused_sat;
  assign unused_sat = ^sat_lane;
`endif

endmodule

// File: tb/tb_bias_act_pipe.sv
// tb_bias_act_pipe: directed self-checking bench for bias_act_pipe.
// Honours BIAS_ACT_SAT_CNT_EN when the build defines it.
module tb_bias_act_pipe;
  import bias_act_pkg::*;

  localparam int N  = 16;
  localparam int W  = 32;
  localparam int LS = 3;

  logic               clk = 1'b0;
  logic               reset;
  logic               bias_wr_en;
  logic [3:0]         bias_wr_index;
  logic [W-1:0]       bias_wr_data;
  logic [1:0]         act_mode;
  logic [W-1:0]       clip_max;
  logic               in_valid;
  logic               in_ready;
  logic [N*W-1:0]     data_in;
  logic               out_valid;
  logic               out_ready;
  logic [N*W-1:0]     data_out;
`ifdef BIAS_ACT_SAT_CNT_EN
  logic [15:0]        sat_count;
`endif

  int checks   = 0;
  int failures = 0;

  logic [N*W-1:0] d;
  logic [N*W-1:0] r;
  int             bpGot;
  int             bpCycles;
  int             drvK;
  int             drvCycles;
  logic           drvAccepted;
  logic           sawDrop;
  logic           holding;
  logic [W-1:0]   held;

  always #5 clk = ~clk;

  bias_act_pipe #(
    .ARRAY_N     (N),
    .DATA_WIDTH  (W),
    .LEAKY_SHIFT (LS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bias_wr_en    (bias_wr_en),
    .bias_wr_index (bias_wr_index),
    .bias_wr_data  (bias_wr_data),
    .act_mode      (act_mode),
    .clip_max      (clip_max),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .data_in       (data_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .data_out      (data_out)
`ifdef BIAS_ACT_SAT_CNT_EN
    ,
    .sat_count     (sat_count)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] laneOf(input logic [N*W-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  function automatic logic [N*W-1:0] splat(input logic [W-1:0] val);
    logic [N*W-1:0] t;
    for (int i = 0; i < N; i++) t[i*W +: W] = val;
    return t;
  endfunction

  function automatic logic bpReady(input int n);
    return ((n % 4) == 0) || ((n % 4) == 3);
  endfunction

  task automatic doReset;
    reset      = 1'b1;
    in_valid   = 1'b0;
    bias_wr_en = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic writeBias(input int idx, input logic [W-1:0] val);
    bias_wr_en    = 1'b1;
    bias_wr_index = 4'(idx);
    bias_wr_data  = val;
    tick;
    bias_wr_en = 1'b0;
  endtask

  task automatic applyStimulus(input logic [N*W-1:0] din, input logic [1:0] m, input logic [W-1:0] c);
    int n;
    n        = 0;
    data_in  = din;
    act_mode = m;
    clip_max = c;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
    tick;
    in_valid = 1'b0;
  endtask

  task automatic collectBeat(output logic [N*W-1:0] dout);
    int n;
    n         = 0;
    out_ready = 1'b1;
    while (!out_valid && n < 50) begin
      tick;
      n++;
    end
    if (!out_valid) checkOutput("output_timeout", 32'd0, 32'd1);
    dout = data_out;
    tick;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    reset         = 1'b1;
    bias_wr_en    = 1'b0;
    bias_wr_index = '0;
    bias_wr_data  = '0;
    act_mode      = ACT_BYPASS;
    clip_max      = '0;
    in_valid      = 1'b0;
    data_in       = '0;
    out_ready     = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    tick;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_data_out", laneOf(data_out, 0), 32'd0);
`ifdef BIAS_ACT_SAT_CNT_EN
    checkOutput("rst_sat_count", 32'(sat_count), 32'd0);
`endif

    // Basic bias + ReLU
    writeBias(3, 32'd100);
    writeBias(0, -32'sd50);
    applyStimulus(splat(32'd10), ACT_RELU, 32'd0);
    checkOutput("lat_s1_not_valid", 32'(out_valid), 32'd0);
    tick;
    checkOutput("lat_s2_valid", 32'(out_valid), 32'd1);
    collectBeat(r);
    checkOutput("relu_lane3", laneOf(r, 3), 32'd110);
    checkOutput("relu_lane0", laneOf(r, 0), 32'd0);
    checkOutput("relu_lane5", laneOf(r, 5), 32'd10);
    checkOutput("relu_lane15", laneOf(r, 15), 32'd10);
`ifdef BIAS_ACT_SAT_CNT_EN
    checkOutput("nosat_count", 32'(sat_count), 32'd0);
`endif

    // Saturation in bypass mode
    writeBias(0, 32'h0000_0100);
    writeBias(1, 32'hFFFF_FFFF);
    d = splat(32'd0);
    d[0*W +: W] = 32'h7FFF_FFF0;
    d[1*W +: W] = 32'h8000_0000;
    d[2*W +: W] = 32'h7FFF_FFFF;
    d[3*W +: W] = 32'd5;
    applyStimulus(d, ACT_BYPASS, 32'd0);
    collectBeat(r);
    checkOutput("sat_pos_lane0", laneOf(r, 0), 32'h7FFF_FFFF);
    checkOutput("sat_neg_lane1", laneOf(r, 1), 32'h8000_0000);
    checkOutput("sat_edge_lane2", laneOf(r, 2), 32'h7FFF_FFFF);
    checkOutput("sat_plain_lane3", laneOf(r, 3), 32'd105);
`ifdef BIAS_ACT_SAT_CNT_EN
    checkOutput("sat_count_one", 32'(sat_count), 32'd1);
`endif

    // Activation modes with zero bias
    doReset;
`ifdef BIAS_ACT_SAT_CNT_EN
    checkOutput("sat_count_cleared", 32'(sat_count), 32'd0);
`endif
    d = splat(32'd0);
    d[0*W +: W] = 32'd80;
    d[1*W +: W] = -32'sd5;
    d[2*W +: W] = -32'sd64;
    d[3*W +: W] = 32'd100;
    d[4*W +: W] = -32'sd1;
    applyStimulus(d, ACT_CLIP, 32'd50);
    collectBeat(r);
    checkOutput("clip_80", laneOf(r, 0), 32'd50);
    checkOutput("clip_m5", laneOf(r, 1), 32'd0);
    checkOutput("clip_m64", laneOf(r, 2), 32'd0);
    checkOutput("clip_100", laneOf(r, 3), 32'd50);
    applyStimulus(d, ACT_LEAKY, 32'd50);
    collectBeat(r);
    checkOutput("leaky_80", laneOf(r, 0), 32'd80);
    checkOutput("leaky_m5", laneOf(r, 1), 32'hFFFF_FFFF);
    checkOutput("leaky_m64", laneOf(r, 2), 32'hFFFF_FFF8);
    checkOutput("leaky_m1", laneOf(r, 4), 32'hFFFF_FFFF);
    applyStimulus(d, ACT_BYPASS, 32'd50);
    collectBeat(r);
    checkOutput("bypass_m64", laneOf(r, 2), 32'hFFFF_FFC0);
    applyStimulus(d, ACT_RELU, 32'd50);
    collectBeat(r);
    checkOutput("relu_m5", laneOf(r, 1), 32'd0);
    checkOutput("relu_100", laneOf(r, 3), 32'd100);
    applyStimulus(d, ACT_CLIP, -32'sd10);
    collectBeat(r);
    checkOutput("clipneg_80", laneOf(r, 0), 32'd0);
    checkOutput("clipneg_100", laneOf(r, 3), 32'd0);

    // Back-pressure stream of 8 beats, out_ready pattern 1,0,0,1
    sawDrop  = 1'b0;
    holding  = 1'b0;
    held     = '0;
    act_mode = ACT_BYPASS;
    fork
      begin
        drvK      = 1;
        drvCycles = 0;
        while (drvK <= 8 && drvCycles < 200) begin
          data_in  = splat(32'(drvK));
          in_valid = 1'b1;
          @(negedge clk);
          drvAccepted = in_ready;
          if (!in_ready) begin
            sawDrop = 1'b1;
            checkOutput("bp_inready_low_when_stalled", 32'(out_valid && !out_ready), 32'd1);
          end
          @(posedge clk);
          #1;
          if (drvAccepted) drvK++;
          drvCycles++;
        end
        in_valid = 1'b0;
      end
      begin
        bpGot    = 0;
        bpCycles = 0;
        while (bpGot < 8 && bpCycles < 200) begin
          out_ready = bpReady(bpCycles);
          @(negedge clk);
          if (holding) begin
            checkOutput("bp_stall_valid", 32'(out_valid), 32'd1);
            checkOutput("bp_stall_stable", laneOf(data_out, 0), held);
          end
          if (out_valid && out_ready) begin
            bpGot++;
            checkOutput($sformatf("bp_order_%0d", bpGot), laneOf(data_out, 0), 32'(bpGot));
            holding = 1'b0;
          end else if (out_valid) begin
            holding = 1'b1;
            held    = laneOf(data_out, 0);
          end else begin
            holding = 1'b0;
          end
          @(posedge clk);
          #1;
          bpCycles++;
        end
      end
    join
    checkOutput("bp_count", 32'(bpGot), 32'd8);
    checkOutput("bp_inready_dropped", 32'(sawDrop), 32'd1);
    out_ready = 1'b1;
    tick;
    tick;
    tick;
    checkOutput("bp_no_extra", 32'(out_valid), 32'd0);

    // Bias write concurrent with an accepted beat
    doReset;
    writeBias(2, 32'd3);
    out_ready     = 1'b1;
    bias_wr_en    = 1'b1;
    bias_wr_index = 4'd2;
    bias_wr_data  = 32'd7;
    data_in       = splat(32'd1);
    act_mode      = ACT_BYPASS;
    in_valid      = 1'b1;
    checkOutput("cw_in_ready", 32'(in_ready), 32'd1);
    tick;
    bias_wr_en = 1'b0;
    in_valid   = 1'b0;
    collectBeat(r);
    checkOutput("cw_old_bias_lane2", laneOf(r, 2), 32'd4);
    checkOutput("cw_lane0", laneOf(r, 0), 32'd1);
    applyStimulus(splat(32'd1), ACT_BYPASS, 32'd0);
    collectBeat(r);
    checkOutput("cw_new_bias_lane2", laneOf(r, 2), 32'd8);

    // Reset with two beats in flight
    out_ready = 1'b0;
    applyStimulus(splat(32'd9), ACT_BYPASS, 32'd0);
    applyStimulus(splat(32'd9), ACT_BYPASS, 32'd0);
    checkOutput("full_in_ready_low", 32'(in_ready), 32'd0);
    checkOutput("full_out_valid", 32'(out_valid), 32'd1);
    checkOutput("full_data_lane2", laneOf(data_out, 2), 32'd16);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_data_lane2", laneOf(data_out, 2), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    applyStimulus(splat(32'd0), ACT_BYPASS, 32'd0);
    collectBeat(r);
    checkOutput("midrst_bias2", laneOf(r, 2), 32'd0);
    checkOutput("midrst_bias0", laneOf(r, 0), 32'd0);
    tick;
    checkOutput("midrst_no_stray", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
